// File: rtl/bram_tdp_be.sv
// bram_tdp_be: true dual-port RAM with byte enables, 1/2-cycle read latency,
// read/write-first mode, hardware clear sweep and same-address collision flag.
module bram_tdp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1 << ADDR_WIDTH,
  parameter int BYTE_W = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int NUM_BE = DATA_WIDTH / BYTE_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_req,
  output logic busy,
  output logic collision,
  input  logic en_a,
  input  logic [NUM_BE-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic dout_valid_a,
  input  logic en_b,
  input  logic [NUM_BE-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic dout_valid_b
);
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_W");
  end
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [1:0] act;
  logic [NUM_BE-1:0] we [2];
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0] din [2], old [2], own [2], rd [2], dq [2];
  logic in_rng [2], wr [2], vq [2];
  logic same, conflict;
  logic [DATA_WIDTH-1:0] wdat_a;
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] o, n,
                                                  input logic [NUM_BE-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = o;
    for (int i = 0; i < NUM_BE; i++)
      if (w[i]) r[i*BYTE_W +: BYTE_W] = n[i*BYTE_W +: BYTE_W];
    return r;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= (state == CLEAR) ? ptr + 1'b1 : '0;
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == CLEAR) ? ((ptr == ADDR_WIDTH'(DEPTH - 1)) ? IDLE : CLEAR)
                                : (clear_req ? CLEAR : IDLE);
  end
  assign busy = (state == CLEAR);
  assign act = {en_b, en_a} & {2{~busy}};
  assign we[0] = we_a;
  assign we[1] = we_b;
  assign addr[0] = addr_a;
  assign addr[1] = addr_b;
  assign din[0] = din_a;
  assign din[1] = din_b;
  assign same = (addr_a == addr_b);
  assign conflict = act[0] && act[1] && same && ((|we_a) || (|we_b));
  // When both ports write one word, A's lanes are layered over B's merge.
  assign wdat_a = (same && wr[1]) ? merge(own[1], din_a, we_a) : own[0];
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] d1;
    logic v1;
    assign in_rng[p] = {1'b0, addr[p]} < (ADDR_WIDTH + 1)'(DEPTH);
    assign old[p] = in_rng[p] ? mem[addr[p]] : CLEAR_VALUE;
    assign own[p] = merge(old[p], din[p], we[p]);
    assign rd[p] = (WRITE_MODE != 0 && in_rng[p]) ? own[p] : old[p];
    assign wr[p] = act[p] && (|we[p]) && in_rng[p];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d1 <= '0;
        v1 <= 1'b0;
      end else begin
        v1 <= act[p];
        if (act[p]) d1 <= rd[p];
      end
    end
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] d2;
      logic v2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign dq[p] = d2;
      assign vq[p] = v2;
    end else begin : g_lat1
      assign dq[p] = d1;
      assign vq[p] = v1;
    end
  end
  always_ff @(posedge clk) begin
    if (busy) mem[ptr] <= CLEAR_VALUE;
    else begin
      if (wr[1]) mem[addr[1]] <= own[1];
      if (wr[0]) mem[addr[0]] <= wdat_a;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else collision <= conflict;
  end
  assign dout_a = dq[0];
  assign dout_valid_a = vq[0];
  assign dout_b = dq[1];
  assign dout_valid_b = vq[1];
endmodule

// File: tb/tb_bram_tdp_be.sv
// tb_bram_tdp_be: checks a latency-1 read-first and a latency-2 write-first
// instance side by side against a reference memory and per-port queues.
module tb_bram_tdp_be;
  logic clk = 0, rst_n = 0, clear_req = 0;
  always #5 clk = ~clk;
  logic en_a = 0, en_b = 0;
  logic [3:0] we_a = 0, we_b = 0, addr_a = 0, addr_b = 0;
  logic [31:0] din_a = 0, din_b = 0;
  logic [31:0] d [4];
  logic v [4];
  logic busy [2], col [2];
  logic [31:0] m [16];
  logic [31:0] q [4][$];
  logic [31:0] e;
  int nchk = 0, npass = 0, nfail = 0;
  bit sweeping = 1;
  bram_tdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .BYTE_W(8), .READ_LATENCY(1),
                .WRITE_MODE(0), .CLEAR_VALUE(32'h0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[0]), .collision(col[0]),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(d[0]), .dout_valid_a(v[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(d[1]), .dout_valid_b(v[1]));
  bram_tdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .BYTE_W(8), .READ_LATENCY(2),
                .WRITE_MODE(1), .CLEAR_VALUE(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[1]), .collision(col[1]),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(d[2]), .dout_valid_a(v[2]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(d[3]), .dout_valid_b(v[3]));
  function automatic logic [31:0] mrg(input logic [31:0] o, n, input logic [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  // Port outputs q[0..3] = u0.A, u0.B, u1.A, u1.B; a valid with nothing queued is a failure.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (v[i]) begin
        if (q[i].size() != 0) e = q[i].pop_front();
        else e = ~d[i];
        check($sformatf("rdata%0d", i), d[i], e);
      end
  end
  task automatic acc(input logic ea, input logic [3:0] wa, aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, ab, input logic [31:0] db,
                     input logic cr = 0);
    logic [31:0] oa, ob;
    @(negedge clk);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    clear_req = cr;
    if (!sweeping) begin
      oa = m[aa];
      ob = m[ab];
      if (ea) begin q[0].push_back(oa); q[2].push_back(mrg(oa, da, wa)); end
      if (eb) begin q[1].push_back(ob); q[3].push_back(mrg(ob, db, wb)); end
      if (eb) m[ab] = mrg(m[ab], db, wb);
      if (ea) m[aa] = mrg(m[aa], da, wa);
    end
  endtask
  task automatic idle();
    acc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd(input logic [3:0] a);
    acc(1, 0, a, 0, 0, 0, 0, 0);
  endtask
  task automatic sweep_count(input bit traffic, input bit poke);
    int n = 0;
    while (busy[0] && n < 100) begin
      @(negedge clk);
      n++;
      clear_req = poke && n == 3;
      en_a = traffic; we_a = 4'($urandom); addr_a = 4'($urandom); din_a = $urandom;
      en_b = traffic; we_b = 4'($urandom); addr_b = 4'($urandom); din_b = $urandom;
    end
    en_a = 0; en_b = 0; clear_req = 0;
    check("busy_edges", n, 16);
    check("busy1_done", busy[1], 0);
    for (int i = 0; i < 16; i++) m[i] = 0;
    sweeping = 0;
  endtask
  task automatic reset_checks();
    check("rst_busy0", busy[0], 1);
    check("rst_busy1", busy[1], 1);
    check("rst_col", {col[0], col[1]}, 0);
    for (int i = 0; i < 4; i++) begin
      check("rst_dout", d[i], 0);
      check("rst_valid", v[i], 0);
    end
  endtask
  initial begin
    #1_000_000;
    $error("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1;
    sweep_count(0, 0);
    // Fill with random data, then reset asynchronously and confirm the wipe
    for (int a = 0; a < 16; a++) acc(1, 4'hF, 4'(a), $urandom, 0, 0, 0, 0);
    repeat (3) idle();
    @(posedge clk);
    #3 rst_n = 0;
    sweeping = 1;
    #1 reset_checks();
    @(negedge clk);
    rst_n = 1;
    sweep_count(1, 0);
    for (int a = 0; a < 16; a++) acc(1, 0, 4'(a), 0, 1, 0, 4'(15 - a), 0);
    idle();
    check("clr_rd_a", d[0], 0);
    check("clr_rd_b", d[1], 0);
    // Byte-lane merge
    acc(1, 4'hF, 5, 32'hAABBCCDD, 0, 0, 0, 0);
    acc(1, 4'b0101, 5, 32'h11223344, 0, 0, 0, 0);
    rd(5);
    idle();
    check("be_merge_l1", d[0], 32'hAA22CC44);
    idle();
    check("be_merge_l2", d[2], 32'hAA22CC44);
    // Same-port read-during-write
    acc(1, 4'hF, 9, 32'hDEADBEEF, 0, 0, 0, 0);
    acc(1, 4'hF, 9, 32'h12345678, 0, 0, 0, 0);
    idle();
    check("read_first", d[0], 32'hDEADBEEF);
    idle();
    check("write_first", d[2], 32'h12345678);
    check("dout_hold", d[0], 32'hDEADBEEF);
    // Both ports write the same word
    acc(1, 4'b0001, 3, 32'h000000FF, 1, 4'hF, 3, 32'hFFFFFF00);
    idle();
    check("col_ww0", col[0], 1);
    check("col_ww1", col[1], 1);
    idle();
    check("col_ww_pulse", col[0], 0);
    rd(3);
    idle();
    check("ww_result", d[0], 32'hFFFFFFFF);
    // A reads while B writes the same word
    acc(1, 4'hF, 7, 32'h11111111, 0, 0, 0, 0);
    idle();
    acc(1, 0, 7, 0, 1, 4'hF, 7, 32'h0BADF00D);
    idle();
    check("rw_old_l1", d[0], 32'h11111111);
    check("col_rw", col[0], 1);
    idle();
    check("rw_old_l2", d[2], 32'h11111111);
    rd(7);
    idle();
    check("rw_new", d[0], 32'h0BADF00D);
    acc(1, 0, 7, 0, 1, 0, 7, 0);
    idle();
    check("col_rr", col[0], 0);
    for (int k = 0; k < 40; k++)
      acc(1'($urandom), 4'($urandom), 4'($urandom), $urandom,
          1'($urandom), 4'($urandom), 4'($urandom), $urandom);
    repeat (3) idle();
    // Clear request during traffic; a second request mid-sweep is ignored
    acc(1, 4'hF, 2, $urandom, 1, 0, 4, 0, 1);
    sweeping = 1;
    idle();
    check("clr_busy", busy[0], 1);
    sweep_count(0, 1);
    for (int a = 0; a < 16; a++) acc(1, 0, 4'(a), 0, 0, 0, 0, 0);
    repeat (3) idle();
    // Reset at sweep address 7 restarts the sweep
    acc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    sweeping = 1;
    idle();
    repeat (7) @(negedge clk);
    rst_n = 0;
    #1 reset_checks();
    @(negedge clk);
    rst_n = 1;
    sweep_count(1, 0);
    for (int a = 8; a < 16; a++) acc(0, 0, 0, 0, 1, 4'hF, 4'(a), $urandom);
    repeat (3) idle();
    // Latency-2 stream of 8 back-to-back reads
    for (int k = 0; k < 8; k++) begin
      rd(4'(8 + k));
      if (k == 1) begin
        check("lat1_valid", v[0], 1);
        check("lat2_early", v[2], 0);
      end
    end
    idle();
    check("stream_v1", v[0], 1);
    check("stream_v2", v[2], 1);
    idle();
    check("stream_v1_end", v[0], 0);
    check("stream_v2_last", v[2], 1);
    idle();
    check("stream_v2_end", v[2], 0);
    repeat (3) idle();
    for (int i = 0; i < 4; i++) check("queue_empty", q[i].size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/bram_tdp_be.md
Name: bram_tdp_be

Overview:
Parametrised true dual-port block RAM, the next generation of the order-book storage RAM. It adds per-byte write enables, a selectable read latency, and a selectable same-port read-during-write mode. It also adds a hardware clear sequencer that wipes the whole array after reset or on request, and same-address collision reporting. Order-book and lookup-table blocks instantiate it in place of the plain dual-port RAM.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_W.
ADDR_WIDTH, 10, address width.
DEPTH, 1<<ADDR_WIDTH, number of words; DEPTH <= 2**ADDR_WIDTH.
BYTE_W, 8, bits per write-enable lane; NUM_BE = DATA_WIDTH/BYTE_W (derived).
READ_LATENCY, 1, 1 or 2 cycles from access to dout; any other value is an elaboration error.
WRITE_MODE, 0, 0 = READ_FIRST, 1 = WRITE_FIRST (same-port read-during-write).
CLEAR_VALUE, 0, DATA_WIDTH-bit word written by the clear sequencer.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
clear_req  in  1  single-cycle request to zero the whole array.
busy  out  1  high while a clear sweep is running; port accesses are ignored.
collision  out  1  one-cycle pulse on a same-address conflict.
en_a  in  1  port A access enable.
we_a  in  NUM_BE  port A byte write enables (all zero = read).
addr_a  in  ADDR_WIDTH  port A address.
din_a  in  DATA_WIDTH  port A write data.
dout_a  out  DATA_WIDTH  port A read data.
dout_valid_a  out  1  port A read-data valid.
en_b, we_b, addr_b, din_b, dout_b, dout_valid_b: port B, identical to port A.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - dout_a, dout_b = 0
  - dout_valid_a, dout_valid_b = 0
  - collision = 0
  - busy = 1, FSM = CLEAR, sweep pointer = 0
  - The array itself has no reset; it is initialised only by the sweep.
- FSM states CLEAR and IDLE:
  - CLEAR: writes CLEAR_VALUE at the pointer on each posedge, then increments the pointer.
  - The last write is to DEPTH-1, on the DEPTH-th posedge after rst_n rises. busy falls at that same edge and the FSM enters IDLE.
  - Port accesses are accepted from the following edge.
  - IDLE: clear_req = 1 moves to CLEAR at the next edge, with busy = 1 and pointer = 0; the first sweep write happens on the edge after that.
  - clear_req during CLEAR is ignored; the sweep does not restart.
  - rst_n low mid-sweep restarts the sweep from address 0.
- Gating while busy = 1:
  - en_a and en_b are treated as 0: no writes, dout_valid stays 0, collision stays 0.
  - dout holds its last value.
- Access with en_x = 1 in IDLE:
  - Each byte lane i with we_x[i] = 1 is written with din_x lane i; all other lanes are unchanged.
  - Every enabled access, read or write, produces read data: dout_x and dout_valid_x = 1 appear READ_LATENCY cycles later.
  - Latency 1: data is registered at the access edge.
  - Latency 2: an additional output register stage; the valid signal is pipelined identically.
  - Back-to-back accesses sustain one per cycle per port.
  - With no access, dout_valid_x = 0 and dout_x holds its previous value (not zeroed).
- Same-port read-during-write:
  - READ_FIRST: dout returns the word as it was before the write.
  - WRITE_FIRST: dout returns the merged word (old bytes plus newly written bytes).
- Cross-port conflict: en_a = en_b = 1, addr_a == addr_b, and at least one of we_a, we_b non-zero.
  - Both writing: lanes enabled on both ports take port A data; lanes enabled only on B take B data.
  - Cross-port read data is always the pre-cycle contents. The reading port sees old data; a writing port sees its own WRITE_MODE result.
  - collision = 1 for exactly the one cycle following the conflicting edge.
  - Two reads of the same address are not a collision.
- Addresses >= DEPTH (when DEPTH < 2**ADDR_WIDTH): writes are dropped; read data is CLEAR_VALUE; dout_valid is still asserted.

Test Plan:
1. DEPTH=16, array pre-filled with random data, rst_n pulsed low then high -> busy high for exactly 16 edges. Every address then reads 0, valid one cycle after en (latency 1).
2. Write 0xAABBCCDD to addr 5 with we=4'b1111; then write 0x11223344 with we=4'b0101; then read -> dout=0xAA22CC44.
3. Same-port write of 0x12345678 over stored 0xDEADBEEF -> WRITE_MODE=0 dout 0xDEADBEEF; WRITE_MODE=1 dout 0x12345678.
4. Same edge: A writes 0x000000FF with we=0001, B writes 0xFFFFFF00 with we=1111, both to addr 3 -> addr 3 = 0xFFFFFFFF; collision pulses one cycle.
5. Same edge: A reads while B writes 0x0BADF00D to an address holding 0x11111111 -> A gets 0x11111111, a later read gets 0x0BADF00D, collision = 1.
6. Reset handling: clear_req pulsed during traffic, rst_n asserted at sweep address 7, READ_LATENCY=2 stream of 8 reads -> sweep restarts at 0 with busy high DEPTH edges. Accesses during busy are ignored with no valid. Reads return data 2 cycles after en, one valid per access.
